sram16_responder: RTL and testbench

Bus responder for the FemtoRV32 memory interface that maps 32-bit CPU accesses onto the BlackIce external 16-bit asynchronous SRAM. It is selected by one address-decoder chip-select line and is the block that drives `mem_rbusy`/`mem_wbusy` back to the CPU, which are currently tied low. Each 32-bit access becomes one or two 16-bit SRAM cycles with a parameterised wait-state count. `mem_rbusy` is held high until the read data is assembled; `mem_wbusy` is held high until all write halves are committed.

---
 rtl/sram16_responder_if.sv | 21 ++
 rtl/sram16_responder.sv | 161 ++++++++++++++++
 tb/tb_sram16_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sram16_responder_if.sv
// CPU-side FemtoRV32 memory bus as seen by the SRAM responder: request, data and busy handshake.
interface sram16_responder_if;
  logic        cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (
    output cs, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  cs, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/sram16_responder.sv
// Maps 32-bit FemtoRV32 accesses onto a 16-bit asynchronous SRAM as one or two
// half-word cycles with WAIT extra wait states; all outputs are registered.
module sram16_responder #(
  parameter int AW   = 18,
  parameter int WAIT = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram16_responder_if.slave    bus,
  output logic [AW-1:0]        sram_addr,
  output logic [15:0]          sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [15:0]          sram_dq_i,
  output logic                 sram_cs_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_lb_n,
  output logic                 sram_ub_n
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_LO     = 3'd1;
  localparam logic [2:0] RD_HI     = 3'd2;
  localparam logic [2:0] WR_LO     = 3'd3;
  localparam logic [2:0] WR_LO_REC = 3'd4;
  localparam logic [2:0] WR_HI     = 3'd5;
  localparam logic [2:0] WR_HI_REC = 3'd6;

  localparam logic [3:0] WAIT_CYC = 4'(WAIT);

  logic [2:0]    state, state_nxt;
  logic [3:0]    wcnt;
  logic [AW-2:0] addr_q, addr_nxt;
  logic [31:0]   wdata_q, wdata_nxt;
  logic [3:0]    wmask_q, wmask_nxt;
  logic [15:0]   rd_lo_q;
  logic [31:0]   rdata_q;
  logic          rbusy_q, wbusy_q;
  logic          in_access, phase_last, accept_wr, accept_rd;

  logic [AW-1:0] addr_d;
  logic [15:0]   dq_o_d;
  logic          dq_oe_d, cs_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[31:AW+1], bus.mem_addr[1:0]};

  assign in_access  = (state == RD_LO) || (state == RD_HI) ||
                      (state == WR_LO) || (state == WR_HI);
  assign phase_last = (wcnt == WAIT_CYC);
  assign accept_wr  = (state == IDLE) && bus.cs && (bus.mem_wmask != 4'b0000);
  assign accept_rd  = (state == IDLE) && bus.cs && bus.mem_rstrb && !accept_wr;

  assign addr_nxt  = (accept_wr || accept_rd) ? bus.mem_addr[AW:2] : addr_q;
  assign wdata_nxt = accept_wr ? bus.mem_wdata : wdata_q;
  assign wmask_nxt = accept_wr ? bus.mem_wmask : wmask_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_wr)      state_nxt = (bus.mem_wmask[1:0] != 2'b00) ? WR_LO : WR_HI;
        else if (accept_rd) state_nxt = RD_LO;
      end
      RD_LO:     if (phase_last) state_nxt = RD_HI;
      RD_HI:     if (phase_last) state_nxt = IDLE;
      WR_LO:     if (phase_last) state_nxt = WR_LO_REC;
      WR_LO_REC: state_nxt = (wmask_q[3:2] != 2'b00) ? WR_HI : IDLE;
      WR_HI:     if (phase_last) state_nxt = WR_HI_REC;
      WR_HI_REC: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pin values are derived from the next state so the registered strobes
  // line up with the state they belong to, starting the cycle after sampling.
  always_comb begin
    addr_d  = sram_addr;
    dq_o_d  = sram_dq_o;
    dq_oe_d = 1'b0;
    cs_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    case (state_nxt)
      RD_LO, RD_HI: begin
        addr_d = {addr_nxt, (state_nxt == RD_HI)};
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
      WR_LO, WR_LO_REC: begin
        addr_d  = {addr_nxt, 1'b0};
        dq_o_d  = wdata_nxt[15:0];
        dq_oe_d = 1'b1;
        cs_n_d  = 1'b0;
        we_n_d  = (state_nxt != WR_LO);
        lb_n_d  = ~wmask_nxt[0];
        ub_n_d  = ~wmask_nxt[1];
      end
      WR_HI, WR_HI_REC: begin
        addr_d  = {addr_nxt, 1'b1};
        dq_o_d  = wdata_nxt[31:16];
        dq_oe_d = 1'b1;
        cs_n_d  = 1'b0;
        we_n_d  = (state_nxt != WR_HI);
        lb_n_d  = ~wmask_nxt[2];
        ub_n_d  = ~wmask_nxt[3];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wcnt       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rd_lo_q    <= '0;
      rdata_q    <= '0;
      rbusy_q    <= 1'b0;
      wbusy_q    <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      state   <= state_nxt;
      wcnt    <= ((state_nxt != state) || !in_access) ? '0 : wcnt + 4'd1;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      wmask_q <= wmask_nxt;
      if ((state == RD_LO) && phase_last) rd_lo_q <= sram_dq_i;
      if ((state == RD_HI) && phase_last) rdata_q <= {sram_dq_i, rd_lo_q};
      rbusy_q    <= (state_nxt == RD_LO) || (state_nxt == RD_HI);
      wbusy_q    <= (state_nxt == WR_LO) || (state_nxt == WR_LO_REC) ||
                    (state_nxt == WR_HI) || (state_nxt == WR_HI_REC);
      sram_addr  <= addr_d;
      sram_dq_o  <= dq_o_d;
      sram_dq_oe <= dq_oe_d;
      sram_cs_n  <= cs_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_lb_n  <= lb_n_d;
      sram_ub_n  <= ub_n_d;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rbusy = rbusy_q;
  assign bus.mem_wbusy = wbusy_q;

endmodule

// File: tb/tb_sram16_responder.sv
// Directed bench for sram16_responder: WAIT=1 instance on a behavioural SRAM, WAIT=3 instance on a fixed-pattern SRAM.
module tb_sram16_responder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram16_responder_if b1();
  sram16_responder_if b3();

  logic [17:0] a1, a3;
  logic [15:0] dqo1, dqo3, dqi1, dqi3;
  logic        oe1, oe3, csn1, csn3, oen1, oen3, wen1, wen3, lbn1, lbn3, ubn1, ubn3;

  sram16_responder #(.AW(18), .WAIT(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(b1.slave),
    .sram_addr(a1), .sram_dq_o(dqo1), .sram_dq_oe(oe1), .sram_dq_i(dqi1),
    .sram_cs_n(csn1), .sram_oe_n(oen1), .sram_we_n(wen1), .sram_lb_n(lbn1), .sram_ub_n(ubn1)
  );

  sram16_responder #(.AW(18), .WAIT(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .bus(b3.slave),
    .sram_addr(a3), .sram_dq_o(dqo3), .sram_dq_oe(oe3), .sram_dq_i(dqi3),
    .sram_cs_n(csn3), .sram_oe_n(oen3), .sram_we_n(wen3), .sram_lb_n(lbn3), .sram_ub_n(ubn3)
  );

  // Behavioural SRAM for the WAIT=1 instance, with a preload port
  logic [15:0] sram [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_a  = '0;
  logic [15:0] pl_d  = '0;

  always @(posedge clk) begin
    if (pl_we) sram[pl_a] <= pl_d;
    else if (!csn1 && !wen1) begin
      if (!lbn1) sram[a1[9:0]][7:0]  <= dqo1[7:0];
      if (!ubn1) sram[a1[9:0]][15:8] <= dqo1[15:8];
    end
  end

  assign dqi1 = (!csn1 && !oen1) ? sram[a1[9:0]] : 16'hDEAD;
  assign dqi3 = (!csn3 && !oen3) ? (a3[0] ? 16'h1357 : 16'h2468) : 16'hDEAD;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-cycle records, bit k-1 / index k = cycle k after the request cycle
  logic [15:0] rbv, wbv, csv, oev, wev, dqoev;
  logic [17:0] av  [1:16];
  logic [15:0] dqv [1:16];
  logic [31:0] rdv [1:16];
  logic [1:0]  lbub[1:16];

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic bus_idle();
    b1.cs = 1'b0; b1.mem_wmask = 4'h0; b1.mem_rstrb = 1'b0;
    b3.cs = 1'b0; b3.mem_wmask = 4'h0; b3.mem_rstrb = 1'b0;
  endtask

  task automatic txn(input bit sel, input bit c, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] wm, input bit rs, input int ncyc);
    @(posedge clk); #1;
    if (sel) begin
      b3.cs = c; b3.mem_addr = adr; b3.mem_wdata = wd; b3.mem_wmask = wm; b3.mem_rstrb = rs;
    end else begin
      b1.cs = c; b1.mem_addr = adr; b1.mem_wdata = wd; b1.mem_wmask = wm; b1.mem_rstrb = rs;
    end
    @(posedge clk); #1;
    bus_idle();
    rbv = '0; wbv = '0; csv = '0; oev = '0; wev = '0; dqoev = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      rbv[k-1]   = sel ? b3.mem_rbusy : b1.mem_rbusy;
      wbv[k-1]   = sel ? b3.mem_wbusy : b1.mem_wbusy;
      csv[k-1]   = sel ? ~csn3 : ~csn1;
      oev[k-1]   = sel ? ~oen3 : ~oen1;
      wev[k-1]   = sel ? ~wen3 : ~wen1;
      dqoev[k-1] = sel ? oe3 : oe1;
      av[k]      = sel ? a3 : a1;
      dqv[k]     = sel ? dqo3 : dqo1;
      rdv[k]     = sel ? b3.mem_rdata : b1.mem_rdata;
      lbub[k]    = sel ? {lbn3, ubn3} : {lbn1, ubn1};
    end
  endtask

  initial begin
    b1.mem_addr = '0; b1.mem_wdata = '0;
    b3.mem_addr = '0; b3.mem_wdata = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", 32'({csn1, oen1, wen1, lbn1, ubn1, oe1}), 32'b111110);
    check("rst_busy", 32'({b1.mem_rbusy, b1.mem_wbusy, b3.mem_rbusy, b3.mem_wbusy}), 32'h0);
    check("rst_addr_dq", {a1[15:0], dqo1}, 32'h0);
    check("rst_rdata", b1.mem_rdata, 32'h0);
    resetn = 1'b1;

    preload(10'h100, 16'hBEEF);
    preload(10'h101, 16'hCAFE);
    preload(10'h009, 16'h4444);

    // Full read, WAIT=1
    txn(0, 1, 32'h200, 32'h0, 4'h0, 1, 8);
    check("rd_rbusy", 32'(rbv[7:0]), 32'h0F);
    check("rd_oe_win", 32'(oev[7:0]), 32'h0F);
    check("rd_addr_lo", 32'(av[2]), 32'h100);
    check("rd_addr_hi", 32'(av[3]), 32'h101);
    check("rd_data_c4", rdv[4], 32'h0);
    check("rd_data_c5", rdv[5], 32'hCAFEBEEF);
    check("rd_wbusy", 32'(wbv[7:0]), 32'h0);

    // Full write
    txn(0, 1, 32'h8, 32'h12345678, 4'hF, 0, 8);
    check("wr_wbusy", 32'(wbv[7:0]), 32'h3F);
    check("wr_we_win", 32'(wev[7:0]), 32'h1B);
    check("wr_dq_oe", 32'(dqoev[7:0]), 32'h3F);
    check("wr_lo_addr_dq", {14'h0, av[1]}, 32'h4);
    check("wr_lo_dq", 32'(dqv[1]), 32'h5678);
    check("wr_hi_addr", 32'(av[4]), 32'h5);
    check("wr_hi_dq", 32'(dqv[4]), 32'h1234);
    check("wr_rec_dq", 32'(dqv[6]), 32'h1234);
    check("wr_mem4", 32'(sram[4]), 32'h5678);
    check("wr_mem5", 32'(sram[5]), 32'h1234);

    // Byte write, HI half only
    txn(0, 1, 32'h8, 32'h00AB0000, 4'b0100, 0, 6);
    check("bw_wbusy", 32'(wbv[5:0]), 32'h07);
    check("bw_we_win", 32'(wev[5:0]), 32'h03);
    check("bw_addr", 32'(av[1]), 32'h5);
    check("bw_lanes", 32'(lbub[1]), 32'b01);
    check("bw_mem5", 32'(sram[5]), 32'h12AB);
    check("bw_mem4", 32'(sram[4]), 32'h5678);

    // Simultaneous read strobe and write: write wins
    txn(0, 1, 32'h10, 32'hFFFF9999, 4'h3, 1, 6);
    check("sim_oe_none", 32'(oev[5:0]), 32'h0);
    check("sim_wbusy", 32'(wbv[5:0]), 32'h07);
    check("sim_rbusy", 32'(rbv[5:0]), 32'h0);
    check("sim_mem8", 32'(sram[8]), 32'h9999);
    check("sim_mem9", 32'(sram[9]), 32'h4444);

    // Deselected request
    txn(0, 0, 32'h200, 32'hFFFFFFFF, 4'hF, 1, 6);
    check("desel_cs", 32'(csv[5:0]), 32'h0);
    check("desel_busy", 32'(rbv[5:0] | wbv[5:0]), 32'h0);
    check("desel_mem", 32'(sram[10'h100]), 32'hBEEF);

    // WAIT=3 read
    txn(1, 1, 32'h0, 32'h0, 4'h0, 1, 12);
    check("w3_rbusy", 32'(rbv[11:0]), 32'h0FF);
    check("w3_data_c8", rdv[8], 32'h0);
    check("w3_data_c9", rdv[9], 32'h13572468);

    // Reset in cycle 2 of a full write
    @(posedge clk); #1;
    b1.cs = 1'b1; b1.mem_addr = 32'h40; b1.mem_wdata = 32'hA5A5A5A5; b1.mem_wmask = 4'hF;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    check("rstw_active", 32'({csn1, wen1, oe1, b1.mem_wbusy}), 32'b0011);
    resetn = 1'b0;
    #1;
    check("rstw_strobes", 32'({csn1, oen1, wen1, lbn1, ubn1, oe1}), 32'b111110);
    check("rstw_busy", 32'({b1.mem_rbusy, b1.mem_wbusy}), 32'h0);
    check("rstw_rdata", b1.mem_rdata, 32'h0);
    #20;
    resetn = 1'b1;

    txn(0, 1, 32'h200, 32'h0, 4'h0, 1, 8);
    check("rd2_rbusy", 32'(rbv[7:0]), 32'h0F);
    check("rd2_data_c5", rdv[5], 32'hCAFEBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
